// File: rtl/adder_operand_serializer.sv
// -----------------------------------------------------------------------------
// adder_operand_serializer
//
// Upstream feeder for the serial adder. It takes a parallel operand pair over a
// valid/ready handshake, streams both operands MSB first on ina/inb with a
// start strobe on en_i, and then watches the adder's response window. The
// window opens on en_o and lasts RESULT_BITS cycles. A new pair is not taken
// until that window closes (done) or the adder never answers (timeout).
//
// Parameters
//   WIDTH       operand width in bits (>= 1)
//   RESULT_BITS length of the adder's response window, in cycles
//   TIMEOUT     max cycles spent waiting for en_o (>= 1)
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand pair valid
//   in_ready  out  block can accept a pair (combinational from state)
//   in_a      in   operand A [WIDTH]
//   in_b      in   operand B [WIDTH]
//   en_i      out  to adder: start-of-transaction strobe (registered)
//   ina       out  to adder: serial A bit (registered)
//   inb       out  to adder: serial B bit (registered)
//   en_o      in   from adder: first result bit valid
//   done      out  one-cycle pulse, response window completed (registered)
//   timeout   out  one-cycle pulse, no en_o within TIMEOUT cycles (registered)
// -----------------------------------------------------------------------------
module adder_operand_serializer #(
  parameter int WIDTH       = 2,
  parameter int RESULT_BITS = WIDTH + 1,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             en_i,
  output logic             ina,
  output logic             inb,
  input  logic             en_o,
  output logic             done,
  output logic             timeout
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int RCW = $clog2(RESULT_BITS + 1);

  localparam logic [BCW-1:0] BIT_LOAD = BCW'(WIDTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT);
  localparam logic [RCW-1:0] RSP_LOAD = RCW'(RESULT_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2,
    S_RSP   = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] sh_a_q,     sh_a_d;
  logic [WIDTH-1:0] sh_b_q,     sh_b_d;
  logic [BCW-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RCW-1:0]   rsp_cnt_q,  rsp_cnt_d;
  logic             en_i_q,     en_i_d;
  logic             ina_q,      ina_d;
  logic             inb_q,      inb_d;
  logic             done_q,     done_d;
  logic             timeout_q,  timeout_d;
  logic [WCW-1:0]   wait_inc_s;

  assign in_ready   = (state_q == S_IDLE);
  assign wait_inc_s = wait_cnt_q + WCW'(1);

  assign en_i    = en_i_q;
  assign ina     = ina_q;
  assign inb     = inb_q;
  assign done    = done_q;
  assign timeout = timeout_q;

  // Next-state and next-output logic. Serial outputs are computed one cycle
  // ahead so that the registered pins show bit WIDTH-1 during the first SHIFT
  // cycle; the shift registers therefore hold the not-yet-sent bits.
  always_comb begin
    state_d    = state_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    en_i_d     = 1'b0;
    ina_d      = 1'b0;
    inb_d      = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = S_SHIFT;
          en_i_d    = 1'b1;
          ina_d     = in_a[WIDTH-1];
          inb_d     = in_b[WIDTH-1];
          sh_a_d    = in_a << 1'b1;
          sh_b_d    = in_b << 1'b1;
          bit_cnt_d = BIT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q - BCW'(1);
        if (bit_cnt_q == BIT_LAST) begin
          // Last bit is on the pins now; lines go quiet next cycle.
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          ina_d  = sh_a_q[WIDTH-1];
          inb_d  = sh_b_q[WIDTH-1];
          sh_a_d = sh_a_q << 1'b1;
          sh_b_d = sh_b_q << 1'b1;
        end
      end

      S_WAIT: begin
        // en_o has priority over an expiring wait count.
        if (en_o) begin
          state_d   = S_RSP;
          rsp_cnt_d = RSP_LOAD;
        end else if (wait_inc_s == WAIT_MAX) begin
          wait_cnt_d = wait_inc_s;
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wait_cnt_d = wait_inc_s;
        end
      end

      S_RSP: begin
        if (rsp_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rsp_cnt_d = rsp_cnt_q - RCW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rsp_cnt_q  <= '0;
      en_i_q     <= 1'b0;
      ina_q      <= 1'b0;
      inb_q      <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      en_i_q     <= en_i_d;
      ina_q      <= ina_d;
      inb_q      <= inb_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_adder_operand_serializer.sv
// -----------------------------------------------------------------------------
// tb_adder_operand_serializer
//
// Directed bench for adder_operand_serializer with default parameters
// (WIDTH=2, RESULT_BITS=3, TIMEOUT=16). The en_o response of the adder is
// driven directly from each vector's delay field. Expected serial bit
// patterns are written by hand in the vector table.
// -----------------------------------------------------------------------------
module tb_adder_operand_serializer;

  localparam int W  = 2;
  localparam int RB = 3;
  localparam int TO = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         en_i;
  logic         ina;
  logic         inb;
  logic         en_o;
  logic         done;
  logic         timeout;

  int checks;
  int failures;

  adder_operand_serializer #(
    .WIDTH(W), .RESULT_BITS(RB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .en_i(en_i), .ina(ina), .inb(inb),
    .en_o(en_o), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // delay: WAIT_RSP cycle (1-based) in which en_o is high; 0 = never.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           delay;
    bit           hold;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    bit           shift_en_o;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input vec_t v);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    if (v.shift_en_o) en_o = 1'b1;
    chk("ready_before_accept", in_ready, 1);
    tick();
    in_valid = v.hold;
    in_a     = v.na;
    in_b     = v.nb;
    for (int i = 0; i < W; i++) begin
      chk("en_i_stream", en_i, (i == 0) ? 1 : 0);
      chk("ina_stream", ina, v.ea[W-1-i]);
      chk("inb_stream", inb, v.eb[W-1-i]);
      chk("ready_low_shift", in_ready, 0);
      chk("done_low_shift", done, 0);
      tick();
    end
    en_o = 1'b0;
    chk("wait_lines_quiet", {en_i, ina, inb}, 0);
    if (v.delay > 0) begin
      for (int c = 1; c < v.delay; c++) begin
        chk("timeout_low_wait", timeout, 0);
        chk("ready_low_wait", in_ready, 0);
        tick();
      end
      en_o = 1'b1;
      tick();
      en_o = 1'b0;
      for (int j = 1; j <= RB; j++) begin
        chk("done_low_rsp", done, 0);
        chk("timeout_low_rsp", timeout, 0);
        chk("ready_low_rsp", in_ready, 0);
        tick();
      end
      chk("done_pulse", done, 1);
      chk("ready_at_done", in_ready, 1);
      chk("timeout_at_done", timeout, 0);
    end else begin
      for (int c = 1; c <= TO; c++) begin
        chk("timeout_low_wait", timeout, 0);
        chk("ready_low_wait", in_ready, 0);
        tick();
      end
      chk("timeout_pulse", timeout, 1);
      chk("ready_at_timeout", in_ready, 1);
      chk("done_at_timeout", done, 0);
      tick();
      chk("timeout_one_cycle", timeout, 0);
      chk("done_after_timeout", done, 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    en_o     = 1'b0;

    //               a      b      ea     eb     dly hold  na     nb    shift_en_o
    vecs[0] = '{2'd3, 2'd2, 2'b11, 2'b10, 1,  1'b0, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{2'd1, 2'd1, 2'b01, 2'b01, 1,  1'b1, 2'd2, 2'd3, 1'b0};
    vecs[2] = '{2'd2, 2'd3, 2'b10, 2'b11, 2,  1'b0, 2'd0, 2'd0, 1'b0};
    vecs[3] = '{2'd0, 2'd3, 2'b00, 2'b11, 0,  1'b0, 2'd0, 2'd0, 1'b0};
    vecs[4] = '{2'd2, 2'd1, 2'b10, 2'b01, 16, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[5] = '{2'd1, 2'd2, 2'b01, 2'b10, 3,  1'b0, 2'd0, 2'd0, 1'b1};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {en_i, ina, inb, done, timeout}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);

    for (int k = 0; k < 6; k++) begin
      txn(vecs[k]);
    end

    // en_o while idle must be ignored.
    tick();
    en_o = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_en_o_ready", in_ready, 1);
      chk("idle_en_o_pulses", {done, timeout}, 0);
    end
    en_o = 1'b0;
    tick();

    // Reset during the second SHIFT cycle.
    in_valid = 1'b1;
    in_a     = 2'd3;
    in_b     = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_en_i", en_i, 1);
    tick();
    chk("pre_rst_ina", ina, 1);
    chk("pre_rst_inb", inb, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_lines", {en_i, ina, inb}, 0);
    chk("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("after_rst_ready", in_ready, 1);
      chk("after_rst_no_pulse", {done, timeout, en_i, ina, inb}, 0);
    end
    txn('{2'd3, 2'd3, 2'b11, 2'b11, 1, 1'b0, 2'd0, 2'd0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
